// File: rtl/bsg_piso_rr_scheduler_pkg.sv
// Shared constants for the round-robin PISO scheduler and its arbiter.
// Stats counter width applies only when BSG_PISO_RR_SCHEDULER_STATS_EN is defined.
package bsg_piso_rr_scheduler_pkg;

  localparam int stats_cnt_width_gp = 16;
  localparam bit assert_en_gp       = 1'b1;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_rr_grant.sv
// Combinational round-robin grant: scans upward from last_i+1 with wrap,
// so the previous grantee always has the lowest priority.
module bsg_rr_grant
  import bsg_piso_rr_scheduler_pkg::*;
#(
  parameter int num_req_p = 1,
  localparam int tag_width_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]    valid_i,
  input  logic [tag_width_lp-1:0] last_i,
  output logic [num_req_p-1:0]    grant_o,
  output logic [tag_width_lp-1:0] id_o,
  output logic                    v_o
);

  int idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    v_o     = 1'b0;
    idx     = 0;
    for (int off = 1; off <= num_req_p; off++) begin
      idx = (int'(last_i) + off) % num_req_p;
      if (!v_o && valid_i[idx[tag_width_lp-1:0]]) begin
        grant_o[idx[tag_width_lp-1:0]] = 1'b1;
        id_o = idx[tag_width_lp-1:0];
        v_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_piso_rr_scheduler.sv
// Round-robin scheduler feeding one serializer: captures a whole packet, then emits it word by word.
// Define BSG_PISO_RR_SCHEDULER_STATS_EN to add grant_cnt_o / busy_cnt_o statistics outputs.
module bsg_piso_rr_scheduler
  import bsg_piso_rr_scheduler_pkg::*;
#(
  parameter int width_p    = -1,
  parameter int els_p      = -1,
  parameter int num_req_p  = -1,
  parameter int hi_to_lo_p = 0,
  localparam int tag_width_lp = safe_clog2(num_req_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               valid_i,
  input  logic [num_req_p*els_p*width_p-1:0] data_i,
  output logic [num_req_p-1:0]               ready_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  output logic [tag_width_lp-1:0]            tag_o,
  output logic                               last_o,
  input  logic                               yumi_i
`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
  ,
  output logic [num_req_p*stats_cnt_width_gp-1:0] grant_cnt_o,
  output logic [31:0]                             busy_cnt_o
`endif
);

  localparam int ctr_width_lp = safe_clog2(els_p);
  localparam logic [ctr_width_lp-1:0] ctr_max_lp = ctr_width_lp'(els_p - 1);

  logic                                         full_q, full_d;
  logic [ctr_width_lp-1:0]                      ctr_q, ctr_d;
  logic [tag_width_lp-1:0]                      tag_q, tag_d;
  logic [tag_width_lp-1:0]                      last_grant_q, last_grant_d;
  logic [els_p-1:0][width_p-1:0]                pkt_q, pkt_d;

  logic [num_req_p-1:0][els_p-1:0][width_p-1:0] data_words;
  logic [els_p-1:0][width_p-1:0]                sel_words, in_words;
  logic [num_req_p-1:0]                         grant;
  logic [tag_width_lp-1:0]                      grant_id;
  logic                                         grant_v;
  logic                                         can_accept, accept;

  bsg_rr_grant #(.num_req_p(num_req_p)) rr_grant (
    .valid_i (valid_i),
    .last_i  (last_grant_q),
    .grant_o (grant),
    .id_o    (grant_id),
    .v_o     (grant_v)
  );

  assign data_words = data_i;
  assign sel_words  = data_words[grant_id];

  // Reversal happens at capture so the output side always counts upward.
  for (genvar k = 0; k < els_p; k++) begin : g_word
    if (hi_to_lo_p != 0) begin : g_rev
      assign in_words[k] = sel_words[els_p-1-k];
    end else begin : g_fwd
      assign in_words[k] = sel_words[k];
    end
  end

  assign valid_o = full_q;
  assign data_o  = pkt_q[ctr_q];
  assign tag_o   = tag_q;
  assign last_o  = full_q & (ctr_q == ctr_max_lp);

  // Taking a new packet while the last word leaves avoids a bubble between packets.
  assign can_accept = ~full_q | (valid_o & yumi_i & last_o);
  assign ready_o    = can_accept ? grant : '0;
  assign accept     = can_accept & grant_v;

  always_comb begin
    full_d       = full_q;
    ctr_d        = ctr_q;
    tag_d        = tag_q;
    last_grant_d = last_grant_q;
    pkt_d        = pkt_q;
    if (accept) begin
      full_d       = 1'b1;
      ctr_d        = '0;
      tag_d        = grant_id;
      last_grant_d = grant_id;
      pkt_d        = in_words;
    end else if (valid_o & yumi_i) begin
      if (last_o) begin
        full_d = 1'b0;
        ctr_d  = '0;
      end else begin
        ctr_d = ctr_q + ctr_width_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      full_q       <= 1'b0;
      ctr_q        <= '0;
      tag_q        <= '0;
      last_grant_q <= tag_width_lp'(num_req_p - 1);
    end else begin
      full_q       <= full_d;
      ctr_q        <= ctr_d;
      tag_q        <= tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pkt_q <= pkt_d;
  end

`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
  logic [num_req_p-1:0][stats_cnt_width_gp-1:0] grant_cnt_q;
  logic [31:0]                                  busy_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      for (int r = 0; r < num_req_p; r++) begin
        if (accept && grant[r] && (grant_cnt_q[r] != '1))
          grant_cnt_q[r] <= grant_cnt_q[r] + stats_cnt_width_gp'(1);
      end
      if (valid_o & ~yumi_i)
        busy_cnt_q <= busy_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign busy_cnt_o  = busy_cnt_q;
`endif

  if (assert_en_gp) begin : g_assert
    logic [num_req_p-1:0] valid_prev_q, ready_prev_q;

    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        valid_prev_q <= '0;
        ready_prev_q <= '0;
      end else begin
        valid_prev_q <= valid_i;
        ready_prev_q <= ready_o;
        assert (!(yumi_i && !valid_o));
        assert ((valid_prev_q & ~ready_prev_q & ~valid_i) == '0);
      end
    end
  end

endmodule

// File: tb/tb_bsg_piso_rr_scheduler.sv
// Scoreboard bench: main instance (3 req, 4 words, lo-first) plus a hi-to-lo instance.
// Stats outputs are checked when BSG_PISO_RR_SCHEDULER_STATS_EN is defined.
module tb_bsg_piso_rr_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  valid_a, ready_a;
  logic [95:0] data_a;
  logic        valid_oa, last_a, yumi_a;
  logic [7:0]  dout_a;
  logic [1:0]  tag_a;

  logic [1:0]  valid_b, ready_b;
  logic [31:0] data_b;
  logic        valid_ob, last_b, yumi_b;
  logic [7:0]  dout_b;
  logic        tag_b;

`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
  logic [47:0] gcnt_a;
  logic [31:0] busy_a;
  logic [31:0] gcnt_b;
  logic [31:0] busy_b;
`endif

  bsg_piso_rr_scheduler #(.width_p(8), .els_p(4), .num_req_p(3), .hi_to_lo_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_a), .data_i(data_a),
    .ready_o(ready_a), .valid_o(valid_oa), .data_o(dout_a), .tag_o(tag_a),
    .last_o(last_a), .yumi_i(yumi_a)
`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
    , .grant_cnt_o(gcnt_a), .busy_cnt_o(busy_a)
`endif
  );

  bsg_piso_rr_scheduler #(.width_p(8), .els_p(2), .num_req_p(2), .hi_to_lo_p(1)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .valid_i(valid_b), .data_i(data_b),
    .ready_o(ready_b), .valid_o(valid_ob), .data_o(dout_b), .tag_o(tag_b),
    .last_o(last_b), .yumi_i(yumi_b)
`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
    , .grant_cnt_o(gcnt_b), .busy_cnt_o(busy_b)
`endif
  );

  typedef struct {
    logic [7:0] d;
    int         tag;
    logic       last;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t qb[$];

  int total = 0;
  int bad   = 0;
  int pend[3];
  int seq[3];
  int exp_gcnt[3];
  int exp_busy = 0;
  int lg = 2;
  int words_out = 0;
  int stall_len = 0;
  int stall_left = 0;
  bit stall_req = 0;
  bit b_acc = 0;
  logic [2:0] acc_seen = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] wd(input int r, input int s, input int k);
    return 8'(16 * r + 4 * s + k);
  endfunction

  function automatic int rr_pick(input logic [2:0] v, input int last);
    for (int o = 1; o <= 3; o++) begin
      int i;
      i = (last + o) % 3;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int r = 0; r < 3; r++) begin
      valid_a[r] = (pend[r] > 0);
      for (int k = 0; k < 4; k++) data_a[(r*4+k)*8 +: 8] = wd(r, seq[r], k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      if (acc_seen[r]) begin
        seq[r]++;
        pend[r]--;
      end
    end
    acc_seen = '0;
    drive_inputs();
    if (b_acc) begin
      valid_b = 2'b00;
      b_acc = 0;
    end
    if (stall_req && valid_oa && q.size() > 0 && q[0].idx == 2) begin
      stall_left = stall_len;
      stall_req = 0;
    end
    yumi_a = valid_oa && (stall_left == 0);
    if (stall_left > 0) stall_left--;
    yumi_b = valid_ob;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!((pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0) &&
                 (q.size() == 0) && !valid_oa) && n < budget);
    if (n >= budget) check("timeout_a", 0, 1);
  endtask

  // Scoreboard for the main instance: pushes a packet when the model predicts an accept.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      lg = 2;
      acc_seen = '0;
      exp_gcnt = '{default: 0};
      exp_busy = 0;
    end else begin
      bit   cap;
      int   pick;
      logic [2:0] exp_ready;
      check("valid_o", valid_oa, q.size() != 0);
      if (valid_oa && q.size() != 0) begin
        check("data_o", dout_a, q[0].d);
        check("tag_o", tag_a, q[0].tag);
        check("last_o", last_a, q[0].last);
      end
      cap = (q.size() == 0) || (yumi_a && q.size() == 1);
      pick = rr_pick(valid_a, lg);
      exp_ready = '0;
      if (cap && pick >= 0) exp_ready[pick] = 1'b1;
      check("ready_o", ready_a, exp_ready);
      if (q.size() != 0 && !yumi_a) exp_busy++;
      if (yumi_a && q.size() != 0) begin
        void'(q.pop_front());
        words_out++;
      end
      acc_seen = valid_a & ready_a;
      if (cap && pick >= 0) begin
        for (int k = 0; k < 4; k++)
          q.push_back('{d: wd(pick, seq[pick], k), tag: pick, last: (k == 3), idx: k});
        lg = pick;
        exp_gcnt[pick]++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      qb.delete();
    end else begin
      check("b_valid_o", valid_ob, qb.size() != 0);
      if (valid_ob && qb.size() != 0) begin
        check("b_data_o", dout_b, qb[0].d);
        check("b_last_o", last_b, qb[0].last);
        check("b_tag_o", tag_b, qb[0].tag);
        if (yumi_b) void'(qb.pop_front());
      end
      check("b_ready_o", ready_b, (valid_b[0] && qb.size() == 0) ? 2'b01 : 2'b00);
      if (valid_b[0] && ready_b[0]) begin
        qb.push_back('{d: 8'hBB, tag: 0, last: 1'b0, idx: 0});
        qb.push_back('{d: 8'hAA, tag: 0, last: 1'b1, idx: 1});
        b_acc = 1;
      end
    end
  end

  initial begin
    int w0, n;
    reset_n = 1'b0;
    valid_a = '0; data_a = '0; yumi_a = 1'b0;
    valid_b = '0; data_b = '0; yumi_b = 1'b0;
    pend = '{default: 0};
    seq  = '{default: 0};
    exp_gcnt = '{default: 0};
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    // single requester, words 0x10..0x13
    pend[1] = 1;
    run_idle(100);

    // full contention, back-to-back packets
    w0 = words_out;
    pend = '{2, 2, 2};
    run_idle(200);
    check("t2_words", words_out - w0, 24);

    // consumer stall on word index 2
    pend[0] = 1; pend[2] = 1;
    stall_len = 5; stall_req = 1;
    run_idle(200);

    // hi-to-lo instance
    data_b = 32'h0000_BBAA;
    valid_b = 2'b01;
    n = 0;
    do begin
      step();
      n++;
    end while (!(valid_b == 2'b00 && qb.size() == 0 && !valid_ob) && n < 50);
    if (n >= 50) check("timeout_b", 0, 1);

    // reset mid-packet, then 3-way contention from fresh priority
    pend[1] = 1;
    w0 = words_out;
    n = 0;
    do begin
      step();
      n++;
    end while ((words_out - w0) < 2 && n < 50);
    if (n >= 50) check("timeout_rst", 0, 1);
    reset_n = 1'b0;
    pend = '{1, 1, 1};
    drive_inputs();
    step();
    reset_n = 1'b1;
    run_idle(200);

    // stats: 5 packets from requester 2 with 3 stall cycles
    reset_n = 1'b0;
    pend = '{0, 0, 0};
    drive_inputs();
    repeat (2) step();
    reset_n = 1'b1;
    pend[2] = 5;
    stall_len = 3; stall_req = 1;
    run_idle(300);
`ifdef BSG_PISO_RR_SCHEDULER_STATS_EN
    check("grant_cnt2", gcnt_a[32 +: 16], exp_gcnt[2]);
    check("grant_cnt0", gcnt_a[0 +: 16], exp_gcnt[0]);
    check("busy_cnt", busy_a, exp_busy);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
